miner_job_dispatcher: RTL and testbench
=======================================

// Module: miner_job_dispatcher
// PURPOSE
//  Initiator side of the miner message interface: accepts a mining job (header template, target, nonce range),
//  loads the target, then drives newMsg/inputMsg once per nonce into the miner core.
//  Samples validBTC/SHAoutput after each hash and reports the first winning nonce, or exhaustion of the range.
//  Sits between the host job interface and the SHA miner core.
// PARAMETERS
//  HASH_LATENCY   230  cycles from newMsg pulse to SHAoutput/validBTC being valid (fixed-latency mode)
//  TARGET_SETTLE  2    idle cycles after the newTarget pulse before the first newMsg
//  NONCE_LSB      0    bit position of the 32-bit nonce field inside inputMsg
// PORTS
//  clk           in   1    clock
//  n_rst         in   1    async active-low reset
//  job_valid     in   1    job offered
//  job_ready     out  1    dispatcher can accept a job (high only in IDLE)
//  job_header    in   408  message template; nonce field is ignored and overwritten
//  job_target    in   256  difficulty target
//  start_nonce   in   32   first nonce to try
//  nonce_count   in   32   number of nonces to try; 0 = none
//  job_abort     in   1    cancel the current job
//  newTarget     out  1    1-cycle target load strobe to the miner
//  inputTarget   out  256  target to the miner; held for the whole job
//  newMsg        out  1    1-cycle message strobe to the miner
//  inputMsg      out  408  job_header with the nonce field replaced; held stable during WAIT
//  SHAoutput     in   256  hash from the miner
//  validBTC      in   1    miner reports hash <= target
//  result_valid  out  1    result available; held until result_ready
//  result_ready  in   1    host accepts the result
//  result_found  out  1    1 = winning nonce found; 0 = range exhausted
//  result_nonce  out  32   winning nonce (last nonce tried if exhausted)
//  result_hash   out  256  SHAoutput captured for result_nonce
// BEHAVIOUR
//  Reset: all outputs 0 except job_ready=1; state=IDLE; internal registers cleared.
//  FSM:
//   IDLE -> LOAD_TGT on job_valid&job_ready. Captures the job; nonce_count==0 goes straight to REPORT with found=0, nonce=start_nonce, hash=0.
//   LOAD_TGT: newTarget=1 for exactly 1 cycle -> SETTLE.
//   SETTLE: wait TARGET_SETTLE cycles -> SEND.
//   SEND: newMsg=1 for exactly 1 cycle; inputMsg carries the current nonce -> WAIT.
//   WAIT: counter counts HASH_LATENCY cycles -> CHECK.
//   CHECK (1 cycle): capture SHAoutput. If validBTC -> REPORT, found=1. Else if remaining==1 -> REPORT, found=0. Else nonce+=1, remaining-=1 -> SEND.
//   REPORT: result_valid=1 with fields stable; on result_ready -> IDLE.
//  Nonce increments mod 2^32: 0xFFFFFFFF wraps to 0x00000000 and does not terminate the job; only remaining==0 terminates.
//  Per-nonce cost: 1+HASH_LATENCY+1 cycles; first newMsg fires 1+TARGET_SETTLE cycles after acceptance.
//  job_abort in any state except IDLE/REPORT -> IDLE next cycle: no result, strobes low, and any in-flight hash is ignored.
//  job_abort in REPORT is ignored.
//  job_abort and job_valid in the same IDLE cycle: the job is accepted and the abort is ignored.
//  Reset mid-job: immediate return to reset values with no result.
// CONFIGURATION
//  MINER_DONE_EN defined:
//   - adds input hashDone (1-bit pulse from the miner); WAIT exits on hashDone instead of the counter.
//   - watchdog of 2*HASH_LATENCY cycles forces REPORT with found=0 and hash=all-ones.
//  MINER_DONE_EN undefined: fixed HASH_LATENCY counter only; no hashDone port.
// STRUCTURE
//  miner_pkg:
//   - MSG_W=408, HASH_W=256, NONCE_W=32
//   - typedef enum dispatch_state_t {IDLE, LOAD_TGT, SETTLE, SEND, WAIT, CHECK, REPORT}
//  Sub-module hash_wait_timer: loadable down-counter shared by SETTLE and WAIT (load, tick, expired; watchdog under MINER_DONE_EN).
// TESTING
//  1. Reset, then idle: job_ready=1; newMsg, newTarget, result_valid all 0.
//  2. Target=0x1000..., start=5, count=3, validBTC tied 0:
//     newMsg pulses at nonces 5, 6, 7, spaced 232 cycles apart; result found=0, nonce=7.
//  3. Same job, validBTC=1 in the CHECK cycle for nonce 6: result found=1, nonce=6,
//     hash = SHAoutput stimulus (e.g. 0xe3b0c442...b855); no newMsg for nonce 7.
//  4. start=0xFFFFFFFF, count=2: newMsg nonces 0xFFFFFFFF then 0x00000000; exhausted with nonce=0.
//  5. count=0: result_valid within 2 cycles; no newTarget or newMsg pulse. Hold result_ready=0 for 10 cycles: result stays stable.
//  6. job_abort mid-WAIT: IDLE next cycle, job_ready=1, no result; next job runs normally.
//     Also assert n_rst mid-SEND: all outputs return to reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared widths and the dispatcher state encoding for the miner job
// dispatcher and its timer.
//   MSG_W    : width of the miner message (header template incl. nonce)
//   HASH_W   : width of hash and target values
//   NONCE_W  : width of the nonce field
//   CNT_W    : width of the SETTLE/WAIT interval counters
// -----------------------------------------------------------------------------
package miner_pkg;

   localparam int MSG_W   = 408;
   localparam int HASH_W  = 256;
   localparam int NONCE_W = 32;
   localparam int CNT_W   = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_TGT,
      SETTLE,
      SEND,
      WAIT,
      CHECK,
      REPORT
   } dispatch_state_t;

endpackage

// File: rtl/hash_wait_timer.sv
// -----------------------------------------------------------------------------
// hash_wait_timer
// Loadable down-counter shared by the SETTLE and WAIT phases of the
// dispatcher. expired_o is high during the last cycle of a loaded interval,
// so an interval of N cycles is load(N) followed by N ticking cycles.
// Optional feature: MINER_DONE_EN adds a watchdog counter (loaded together
// with the main counter) that bounds how long WAIT may wait for hashDone.
// Ports:
//   clk, n_rst    : clock, async active-low reset
//   load_i        : load the counter(s) this cycle
//   load_val_i    : interval length for the main counter
//   tick_i        : count down one step
//   expired_o     : current cycle is the last of the interval
//   wd_val_i      : (MINER_DONE_EN) watchdog interval length
//   wd_expired_o  : (MINER_DONE_EN) watchdog interval used up
// -----------------------------------------------------------------------------
module hash_wait_timer
   import miner_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             tick_i,
   output logic             expired_o
`ifdef MINER_DONE_EN
   ,
   input  logic [CNT_W-1:0] wd_val_i,
   output logic             wd_expired_o
`endif
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                    cnt_d = load_val_i;
      else if (tick_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
   end

   // <=1 rather than ==1 so a zero-length load still lets the phase exit.
   assign expired_o = (cnt_q <= CNT_W'(1));

`ifdef MINER_DONE_EN
   logic [CNT_W-1:0] wd_q, wd_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) wd_q <= '0;
      else        wd_q <= wd_d;
   end

   always_comb begin
      wd_d = wd_q;
      if (load_i)                   wd_d = wd_val_i;
      else if (tick_i && wd_q != '0) wd_d = wd_q - 1'b1;
   end

   assign wd_expired_o = (wd_q <= CNT_W'(1));
`endif

endmodule

// File: rtl/miner_job_dispatcher.sv
// -----------------------------------------------------------------------------
// miner_job_dispatcher
// Accepts a mining job from the host, loads the target into the miner core,
// then issues one message per nonce and inspects validBTC/SHAoutput after each
// hash. Reports the first winning nonce or exhaustion of the nonce range.
// Handshakes: job_valid/job_ready and result_valid/result_ready transfer on a
// clock edge where both are high; a producer holds valid and its payload
// stable until that edge.
// Optional feature: MINER_DONE_EN adds the hashDone input; WAIT then ends on
// hashDone, with a 2*HASH_LATENCY watchdog that reports found=0, hash=all-ones.
// Ports:
//   clk, n_rst                  : clock, async active-low reset
//   job_valid/job_ready         : job handshake (ready only in IDLE)
//   job_header/job_target       : message template and difficulty target
//   start_nonce/nonce_count     : nonce range (count 0 = empty job)
//   job_abort                   : cancel an active job (ignored in IDLE/REPORT)
//   newTarget/inputTarget       : target load strobe and value to the miner
//   newMsg/inputMsg             : message strobe and message to the miner
//   SHAoutput/validBTC          : miner result, sampled in CHECK
//   hashDone                    : (MINER_DONE_EN) miner hash-complete pulse
//   result_*                    : result handshake and payload
//   dbg_state_o                 : current FSM state for observation
// -----------------------------------------------------------------------------
module miner_job_dispatcher
   import miner_pkg::*;
#(
   parameter int unsigned HASH_LATENCY  = 230,
   parameter int unsigned TARGET_SETTLE = 2,
   parameter int unsigned NONCE_LSB     = 0
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [MSG_W-1:0]   job_header,
   input  logic [HASH_W-1:0]  job_target,
   input  logic [NONCE_W-1:0] start_nonce,
   input  logic [NONCE_W-1:0] nonce_count,
   input  logic               job_abort,
   output logic               newTarget,
   output logic [HASH_W-1:0]  inputTarget,
   output logic               newMsg,
   output logic [MSG_W-1:0]   inputMsg,
   input  logic [HASH_W-1:0]  SHAoutput,
   input  logic               validBTC,
`ifdef MINER_DONE_EN
   input  logic               hashDone,
`endif
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_found,
   output logic [NONCE_W-1:0] result_nonce,
   output logic [HASH_W-1:0]  result_hash,
   output dispatch_state_t    dbg_state_o
);

   dispatch_state_t    state_q, state_d;
   logic [MSG_W-1:0]   header_q, header_d;
   logic [HASH_W-1:0]  target_q, target_d;
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [NONCE_W-1:0] remaining_q, remaining_d;
   logic               found_q, found_d;
   logic [NONCE_W-1:0] res_nonce_q, res_nonce_d;
   logic [HASH_W-1:0]  res_hash_q, res_hash_d;

   logic               tmr_load, tmr_tick, tmr_expired;
   logic [CNT_W-1:0]   tmr_load_val;

   // LOAD_TGT arms the settle interval, SEND arms the hash latency interval.
   assign tmr_load     = (state_q == LOAD_TGT) || (state_q == SEND);
   assign tmr_load_val = (state_q == LOAD_TGT) ? CNT_W'(TARGET_SETTLE) : CNT_W'(HASH_LATENCY);
   assign tmr_tick     = (state_q == SETTLE) || (state_q == WAIT);

`ifdef MINER_DONE_EN
   logic wd_expired;

   hash_wait_timer u_timer (
      .clk          (clk),
      .n_rst        (n_rst),
      .load_i       (tmr_load),
      .load_val_i   (tmr_load_val),
      .tick_i       (tmr_tick),
      .expired_o    (tmr_expired),
      .wd_val_i     (CNT_W'(2 * HASH_LATENCY)),
      .wd_expired_o (wd_expired)
   );
`else
   hash_wait_timer u_timer (
      .clk        (clk),
      .n_rst      (n_rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .tick_i     (tmr_tick),
      .expired_o  (tmr_expired)
   );
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         header_q    <= '0;
         target_q    <= '0;
         nonce_q     <= '0;
         remaining_q <= '0;
         found_q     <= 1'b0;
         res_nonce_q <= '0;
         res_hash_q  <= '0;
      end else begin
         state_q     <= state_d;
         header_q    <= header_d;
         target_q    <= target_d;
         nonce_q     <= nonce_d;
         remaining_q <= remaining_d;
         found_q     <= found_d;
         res_nonce_q <= res_nonce_d;
         res_hash_q  <= res_hash_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      header_d    = header_q;
      target_d    = target_q;
      nonce_d     = nonce_q;
      remaining_d = remaining_q;
      found_d     = found_q;
      res_nonce_d = res_nonce_q;
      res_hash_d  = res_hash_q;

      case (state_q)
         IDLE: begin
            if (job_valid) begin
               header_d    = job_header;
               target_d    = job_target;
               nonce_d     = start_nonce;
               remaining_d = nonce_count;
               if (nonce_count == '0) begin
                  // Empty range: report immediately, miner untouched.
                  found_d     = 1'b0;
                  res_nonce_d = start_nonce;
                  res_hash_d  = '0;
                  state_d     = REPORT;
               end else begin
                  state_d = LOAD_TGT;
               end
            end
         end
         LOAD_TGT: state_d = SETTLE;
         SETTLE:   if (tmr_expired) state_d = SEND;
         SEND:     state_d = WAIT;
         WAIT: begin
`ifdef MINER_DONE_EN
            if (hashDone) begin
               state_d = CHECK;
            end else if (wd_expired) begin
               found_d     = 1'b0;
               res_nonce_d = nonce_q;
               res_hash_d  = '1;
               state_d     = REPORT;
            end
`else
            if (tmr_expired) state_d = CHECK;
`endif
         end
         CHECK: begin
            res_hash_d  = SHAoutput;
            res_nonce_d = nonce_q;
            if (validBTC) begin
               found_d = 1'b1;
               state_d = REPORT;
            end else if (remaining_q == NONCE_W'(1)) begin
               found_d = 1'b0;
               state_d = REPORT;
            end else begin
               // Wraps mod 2^32; only the remaining count ends the job.
               nonce_d     = nonce_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = SEND;
            end
         end
         REPORT:  if (result_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort wins over every transition of an active job; REPORT keeps its result.
      if (job_abort && (state_q != IDLE) && (state_q != REPORT)) state_d = IDLE;
   end

   // Outputs decoded from registered state.
   always_comb begin
      job_ready    = (state_q == IDLE);
      newTarget    = (state_q == LOAD_TGT);
      newMsg       = (state_q == SEND);
      result_valid = (state_q == REPORT);
      inputMsg     = header_q;
      inputMsg[NONCE_LSB +: NONCE_W] = nonce_q;
   end

   assign inputTarget  = target_q;
   assign result_found = found_q;
   assign result_nonce = res_nonce_q;
   assign result_hash  = res_hash_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_miner_job_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_miner_job_dispatcher
// Self-checking bench for miner_job_dispatcher (default build, fixed latency).
// A behavioural miner returns hash_of(nonce) exactly in the CHECK cycle of each
// message; the expected nonce sequence and the expected result of every job
// are queued when the job is submitted and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_miner_job_dispatcher;
   import miner_pkg::*;

   localparam int LAT     = 230;
   localparam int SETTLE  = 2;
   localparam logic [255:0] SHA_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TGT = 256'h1000 << 240;

   typedef struct {
      logic         found;
      logic [31:0]  nonce;
      logic [255:0] hash;
   } res_t;

   // ---------------- clock / reset ----------------
   logic clk, n_rst;
   int   cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // ---------------- DUT ----------------
   logic            job_valid, job_ready, job_abort;
   logic [407:0]    job_header;
   logic [255:0]    job_target;
   logic [31:0]     start_nonce, nonce_count;
   logic            newTarget, newMsg;
   logic [255:0]    inputTarget;
   logic [407:0]    inputMsg;
   logic [255:0]    SHAoutput;
   logic            validBTC;
   logic            result_valid, result_ready, result_found;
   logic [31:0]     result_nonce;
   logic [255:0]    result_hash;
   dispatch_state_t dbg_state;

   miner_job_dispatcher dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_header   (job_header),
      .job_target   (job_target),
      .start_nonce  (start_nonce),
      .nonce_count  (nonce_count),
      .job_abort    (job_abort),
      .newTarget    (newTarget),
      .inputTarget  (inputTarget),
      .newMsg       (newMsg),
      .inputMsg     (inputMsg),
      .SHAoutput    (SHAoutput),
      .validBTC     (validBTC),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_found (result_found),
      .result_nonce (result_nonce),
      .result_hash  (result_hash),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [31:0]  exp_q[$];
   res_t         res_q[$];
   int           vectors, miscompares;
   int           tgt_cnt, msg_cnt, tgt_cyc, last_msg_cyc;
   bit           first_msg;
   bit           win_en;
   logic [31:0]  win_nonce;
   logic [407:0] cur_hdr;
   logic [255:0] cur_tgt;

   function automatic logic [255:0] hash_of(input logic [31:0] n);
      return SHA_EMPTY ^ {224'b0, n};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- miner model + message monitor ----------------
   initial begin
      int          mdl_cnt;
      logic [31:0] mdl_nonce;
      logic [31:0] exp_n;
      mdl_cnt   = -1;
      mdl_nonce = '0;
      SHAoutput = '0;
      validBTC  = 1'b0;
      forever begin
         @(negedge clk);
         SHAoutput = '0;
         validBTC  = 1'b0;
         if (!n_rst) begin
            mdl_cnt = -1;
         end else begin
            // Result presented only during the CHECK cycle: SEND + 1 + LAT.
            if (mdl_cnt == 0) begin
               SHAoutput = hash_of(mdl_nonce);
               validBTC  = win_en && (mdl_nonce == win_nonce);
               mdl_cnt   = -1;
            end else if (mdl_cnt > 0) begin
               mdl_cnt--;
            end
            if (newTarget) begin
               tgt_cnt++;
               tgt_cyc = cyc;
            end
            if (newMsg) begin
               msg_cnt++;
               mdl_nonce = inputMsg[31:0];
               mdl_cnt   = LAT;
               check("msg_expected", 256'(exp_q.size() != 0), 256'(1));
               if (exp_q.size() != 0) begin
                  exp_n = exp_q.pop_front();
                  check("msg_nonce", 256'(inputMsg[31:0]), 256'(exp_n));
                  check("msg_header", 256'(inputMsg[407:32] ^ cur_hdr[407:32]), 256'(0));
                  check("msg_target", inputTarget, cur_tgt);
               end
               if (first_msg) check("first_msg_lat", 256'(cyc - tgt_cyc), 256'(1 + SETTLE));
               else           check("msg_spacing", 256'(cyc - last_msg_cyc), 256'(LAT + 2));
               first_msg    = 1'b0;
               last_msg_cyc = cyc;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic submit(input logic [31:0] start, input logic [31:0] cnt,
                         input bit w_en, input logic [31:0] w_nonce);
      logic [415:0] raw;
      logic [31:0]  n;
      res_t         r;
      bit           done;
      for (int i = 0; i < 13; i++) raw[i*32 +: 32] = $urandom();
      cur_hdr   = raw[407:0];
      cur_tgt   = TGT;
      win_en    = w_en;
      win_nonce = w_nonce;
      first_msg = 1'b1;
      done      = 1'b0;
      r.found   = 1'b0;
      r.nonce   = start;
      r.hash    = '0;
      for (longint i = 0; i < longint'(cnt) && !done; i++) begin
         n = start + 32'(i);
         exp_q.push_back(n);
         if (w_en && n == w_nonce) begin
            r.found = 1'b1; r.nonce = n; r.hash = hash_of(n); done = 1'b1;
         end else if (i == longint'(cnt) - 1) begin
            r.found = 1'b0; r.nonce = n; r.hash = hash_of(n); done = 1'b1;
         end
      end
      res_q.push_back(r);
      job_header  = cur_hdr;
      job_target  = cur_tgt;
      start_nonce = start;
      nonce_count = cnt;
      job_valid   = 1'b1;
      @(negedge clk);
      job_valid   = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int bound);
      res_t r;
      int   i;
      i = 0;
      while (!result_valid && i < bound) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_valid"}, 256'(result_valid), 256'(1));
      if (result_valid && res_q.size() != 0) begin
         r = res_q.pop_front();
         check({tag, "_found"}, 256'(result_found), 256'(r.found));
         check({tag, "_nonce"}, 256'(result_nonce), 256'(r.nonce));
         check({tag, "_hash"}, result_hash, r.hash);
      end
      check({tag, "_msgq"}, 256'(exp_q.size()), 256'(0));
   endtask

   task automatic ack();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("ack_job_ready", 256'(job_ready), 256'(1));
      check("ack_rv_low", 256'(result_valid), 256'(0));
   endtask

   task automatic wait_msg(input string tag);
      int i;
      i = 0;
      while (!newMsg && i < 20) begin
         @(negedge clk);
         i++;
      end
      check(tag, 256'(newMsg), 256'(1));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int t0, m0;
      bit any_rv;
      n_rst        = 1'b0;
      job_valid    = 1'b0;
      job_abort    = 1'b0;
      job_header   = '0;
      job_target   = '0;
      start_nonce  = '0;
      nonce_count  = '0;
      result_ready = 1'b0;
      win_en       = 1'b0;
      win_nonce    = '0;
      first_msg    = 1'b1;
      cur_hdr      = '0;
      cur_tgt      = '0;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // 1. reset / idle
      check("rst_job_ready", 256'(job_ready), 256'(1));
      check("rst_newMsg", 256'(newMsg), 256'(0));
      check("rst_newTarget", 256'(newTarget), 256'(0));
      check("rst_result_valid", 256'(result_valid), 256'(0));
      check("rst_state", 256'(dbg_state), 256'(IDLE));

      // 2. exhausted range 5..7
      t0 = tgt_cnt;
      submit(32'd5, 32'd3, 1'b0, 32'd0);
      wait_result("exh", 1000);
      check("exh_tgt_pulses", 256'(tgt_cnt - t0), 256'(1));
      ack();

      // 3. winner at nonce 6, nothing sent for 7
      submit(32'd5, 32'd3, 1'b1, 32'd6);
      wait_result("win", 1000);
      ack();

      // 4. nonce wrap
      submit(32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0);
      wait_result("wrap", 800);
      ack();

      // 5. empty job, result held while not accepted
      t0 = tgt_cnt;
      m0 = msg_cnt;
      submit(32'd42, 32'd0, 1'b0, 32'd0);
      wait_result("empty", 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("empty_hold_valid", 256'(result_valid), 256'(1));
         check("empty_hold_nonce", 256'(result_nonce), 256'(32'd42));
      end
      check("empty_no_target", 256'(tgt_cnt - t0), 256'(0));
      check("empty_no_msg", 256'(msg_cnt - m0), 256'(0));
      ack();

      // 6a. abort mid-WAIT
      submit(32'd100, 32'd5, 1'b0, 32'd0);
      wait_msg("abort_send_seen");
      repeat (50) @(negedge clk);
      job_abort = 1'b1;
      @(negedge clk);
      job_abort = 1'b0;
      check("abort_job_ready", 256'(job_ready), 256'(1));
      check("abort_state", 256'(dbg_state), 256'(IDLE));
      exp_q.delete();
      res_q.delete();
      m0     = msg_cnt;
      any_rv = 1'b0;
      repeat (300) begin
         @(negedge clk);
         any_rv |= result_valid;
      end
      check("abort_no_result", 256'(any_rv), 256'(0));
      check("abort_no_msg", 256'(msg_cnt - m0), 256'(0));
      submit(32'd200, 32'd1, 1'b0, 32'd0);
      wait_result("post_abort", 400);
      ack();

      // 6b. reset during SEND
      submit(32'd300, 32'd4, 1'b0, 32'd0);
      wait_msg("rst_send_seen");
      #2 n_rst = 1'b0;
      #1;
      check("midrst_job_ready", 256'(job_ready), 256'(1));
      check("midrst_newMsg", 256'(newMsg), 256'(0));
      check("midrst_newTarget", 256'(newTarget), 256'(0));
      check("midrst_result_valid", 256'(result_valid), 256'(0));
      check("midrst_inputMsg", 256'(inputMsg != '0), 256'(0));
      check("midrst_inputTarget", inputTarget, 256'(0));
      exp_q.delete();
      res_q.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      check("postrst_state", 256'(dbg_state), 256'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
